note_tone_gen: RTL

Takes an (octave, note) pair, in the format produced by the note-number-to-octave/note splitter, and produces a square-wave speaker drive at that pitch. It is the consumer end of that octave/note interface in the MusicBox chain. Pitch is set by a per-note base divider, scaled by a per-octave repeat counter. Notes are loaded over a valid/ready handshake, and note changes take effect only on a half-period boundary, so the output is glitch-free.

---
 rtl/note_tone_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: consumes an (octave, note) pair over valid/ready and
// toggles the speaker every DIV[note]*((OCT_BASE>>octave)+1) cycles.
module note_tone_gen #(
    parameter logic [7:0] OCT_BASE   = 8'd255,
    parameter int         NOTE_DIV_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] octave,
    input  logic [3:0] note,
    input  logic       note_valid,
    output logic       note_ready,
    input  logic       stop,
    output logic       speaker,
    output logic       playing,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        REST = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [NOTE_DIV_W-1:0]   cnt_n, cnt_n_next;
    logic [7:0]              cnt_o, cnt_o_next;
    logic [2:0]              oct_q, oct_next;
    logic [3:0]              note_q, note_next;
    logic                    speaker_next;
    logic                    boundary;
    logic                    accept;
    logic                    pair_ok;

    // Handshake: a pair transfers on any edge where note_valid && note_ready and
    // stop is low; the source holds octave/note stable until then.

    // Divider table stored as DIV-1 so it loads straight into the down-counter.
    function automatic logic [NOTE_DIV_W-1:0] div_m1(input logic [3:0] n);
        case (n)
            4'd0:    div_m1 = NOTE_DIV_W'(511);
            4'd1:    div_m1 = NOTE_DIV_W'(482);
            4'd2:    div_m1 = NOTE_DIV_W'(455);
            4'd3:    div_m1 = NOTE_DIV_W'(430);
            4'd4:    div_m1 = NOTE_DIV_W'(405);
            4'd5:    div_m1 = NOTE_DIV_W'(383);
            4'd6:    div_m1 = NOTE_DIV_W'(361);
            4'd7:    div_m1 = NOTE_DIV_W'(341);
            4'd8:    div_m1 = NOTE_DIV_W'(322);
            4'd9:    div_m1 = NOTE_DIV_W'(303);
            4'd10:   div_m1 = NOTE_DIV_W'(286);
            4'd11:   div_m1 = NOTE_DIV_W'(270);
            default: div_m1 = '0;
        endcase
    endfunction

    function automatic logic [7:0] oct_count(input logic [2:0] o);
        oct_count = OCT_BASE >> o;
    endfunction

    assign boundary   = (state == PLAY) && (cnt_n == '0) && (cnt_o == 8'd0);
    assign note_ready = (state != PLAY) || boundary;
    assign accept     = note_valid && note_ready && !stop;
    assign pair_ok    = (note <= 4'd11) && (octave <= 3'd5);
    assign state_dbg  = state;

    always_comb begin
        state_next   = state;
        cnt_n_next   = cnt_n;
        cnt_o_next   = cnt_o;
        speaker_next = speaker;
        oct_next     = oct_q;
        note_next    = note_q;
        if (stop) begin
            state_next   = IDLE;
            cnt_n_next   = '0;
            cnt_o_next   = 8'd0;
            speaker_next = 1'b0;
        end else if (accept) begin
            oct_next  = octave;
            note_next = note;
            if (pair_ok) begin
                state_next   = PLAY;
                cnt_n_next   = div_m1(note);
                cnt_o_next   = oct_count(octave);
                // In PLAY an accept only happens on a boundary, where the toggle is due anyway.
                speaker_next = (state == PLAY) ? ~speaker : 1'b0;
            end else begin
                state_next   = REST;
                cnt_n_next   = '0;
                cnt_o_next   = 8'd0;
                speaker_next = 1'b0;
            end
        end else if (state == PLAY) begin
            if (cnt_n != '0) begin
                cnt_n_next = cnt_n - NOTE_DIV_W'(1);
            end else begin
                cnt_n_next = div_m1(note_q);
                if (cnt_o != 8'd0) begin
                    cnt_o_next = cnt_o - 8'd1;
                end else begin
                    cnt_o_next   = oct_count(oct_q);
                    speaker_next = ~speaker;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt_n   <= '0;
            cnt_o   <= 8'd0;
            oct_q   <= 3'd0;
            note_q  <= 4'd0;
            speaker <= 1'b0;
            playing <= 1'b0;
        end else begin
            state   <= state_next;
            cnt_n   <= cnt_n_next;
            cnt_o   <= cnt_o_next;
            oct_q   <= oct_next;
            note_q  <= note_next;
            speaker <= speaker_next;
            playing <= (state_next == PLAY);
        end
    end

endmodule
